// File: rtl/hazard_if.sv
// hazard_if: bundles the signals exchanged between the pipeline datapath
// and the hazard control unit.
//   master : pipeline side; drives ID/EX/MEM status and consumes the controls
//   slave  : hazard control unit; consumes status and drives the controls
// Status : id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
//          ex_branch_taken, mem_req, mem_ready
// Control: stall, flush, pc_write_en, if_id_write_en
interface hazard_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  stall;
  logic                  flush;
  logic                  pc_write_en;
  logic                  if_id_write_en;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  stall, flush, pc_write_en, if_id_write_en
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output stall, flush, pc_write_en, if_id_write_en
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush generation for the decode stage.
//   - load-use hazard: one-cycle bubble (stall, PC and IF/ID frozen)
//   - taken branch   : flush held for FLUSH_CYCLES cycles
//   - memory wait    : pipeline frozen until the data memory is ready
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   hif      : hazard_if.slave (ID/EX/MEM status in, stall/flush/enables out)
//   stall_cycles, flush_events : saturating statistics counters, present only
//                                when HAZARD_STATS_EN is defined
// Optional feature macro: HAZARD_STATS_EN
// All controls are combinational from the state and current inputs, and are
// forced to 0 while rst is high.
module hazard_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  hazard_if.slave hif
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t         state_reg, state_next;
  logic [FCW-1:0] flush_cnt_reg, flush_cnt_next;

  logic load_use;
  logic mem_wait;
  logic stall_c;
  logic flush_c;
  logic we_c;
  logic branch_accept;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = hif.ex_mem_read && (hif.ex_rd != REG_ZERO) &&
                    ((hif.id_rs1_used && (hif.id_rs1 == hif.ex_rd)) ||
                     (hif.id_rs2_used && (hif.id_rs2 == hif.ex_rd)));

  assign mem_wait = hif.mem_req && !hif.mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    stall_c        = 1'b0;
    flush_c        = 1'b0;
    we_c           = 1'b1;
    branch_accept  = 1'b0;

    case (state_reg)
      FLUSH: begin
        if (mem_wait) begin
          // The freeze wins; the outstanding flush count is dropped.
          stall_c        = 1'b1;
          we_c           = 1'b0;
          state_next     = MEM_WAIT;
          flush_cnt_next = '0;
        end else begin
          // load_use is deliberately ignored: the ID contents are squashed.
          flush_c = 1'b1;
          if (hif.ex_branch_taken) begin
            branch_accept  = 1'b1;
            flush_cnt_next = FLUSH_RELOAD;
          end else if (flush_cnt_reg <= FCW'(1)) begin
            state_next     = RUN;
            flush_cnt_next = '0;
          end else begin
            flush_cnt_next = flush_cnt_reg - FCW'(1);
          end
        end
      end

      RUN, MEM_WAIT: begin
        if (state_reg == MEM_WAIT && !hif.mem_ready) begin
          stall_c = 1'b1;
          we_c    = 1'b0;
        end else begin
          // The mem_ready cycle of MEM_WAIT behaves exactly like RUN.
          state_next     = RUN;
          flush_cnt_next = '0;
          if (mem_wait) begin
            // EX is held, so any taken branch is re-presented later.
            stall_c    = 1'b1;
            we_c       = 1'b0;
            state_next = MEM_WAIT;
          end else if (hif.ex_branch_taken) begin
            flush_c       = 1'b1;
            branch_accept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next     = FLUSH;
              flush_cnt_next = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            // Single bubble: it clears ex_mem_read on the next cycle.
            stall_c = 1'b1;
            we_c    = 1'b0;
          end
        end
      end

      default: begin
        state_next     = RUN;
        flush_cnt_next = '0;
      end
    endcase
  end

  assign hif.stall          = stall_c && !rst;
  assign hif.flush          = flush_c && !rst;
  assign hif.pc_write_en    = we_c && !rst;
  assign hif.if_id_write_en = we_c && !rst;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_c && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (branch_accept && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: scoreboard bench for hazard_control_unit.
// Expected control vectors {stall, flush, pc_we, if_id_we} are queued when a
// cycle's stimulus is driven and popped when the outputs are sampled 4 ns
// after the rising edge. Statistics checks are compiled with HAZARD_STATS_EN.
module tb_hazard_control_unit;

  localparam logic [3:0] O_ZERO   = 4'b0000;
  localparam logic [3:0] O_NORMAL = 4'b0011;
  localparam logic [3:0] O_STALL  = 4'b1000;
  localparam logic [3:0] O_FLUSH  = 4'b0111;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       bt;
    logic       mq;
    logic       mrdy;
  } stim_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];

  hazard_if #(.REG_ADDR_W(5)) hif();

`ifdef HAZARD_STATS_EN
  logic [1:0] stall_cycles;
  logic [1:0] flush_events;
  logic [3:0] cnt_q[$];

  hazard_control_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .hif(hif),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
`else
  hazard_control_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .hif(hif)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic bt, input logic mq,
                               input logic mrdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.mr = mr; s.bt = bt; s.mq = mq; s.mrdy = mrdy;
    return s;
  endfunction

  function automatic logic [3:0] obs();
    return {hif.stall, hif.flush, hif.pc_write_en, hif.if_id_write_en};
  endfunction

  task automatic apply(input stim_t s);
    hif.id_rs1          = s.rs1;
    hif.id_rs2          = s.rs2;
    hif.id_rs1_used     = s.u1;
    hif.id_rs2_used     = s.u2;
    hif.ex_rd           = s.rd;
    hif.ex_mem_read     = s.mr;
    hif.ex_branch_taken = s.bt;
    hif.mem_req         = s.mq;
    hif.mem_ready       = s.mrdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Common stimulus patterns
  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic stim_t lu();
    return mk(5, 0, 1, 0, 5, 1, 0, 0, 0);
  endfunction
  function automatic stim_t br();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic stim_t mwait();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  task automatic test_reset();
    logic [3:0] got, want;
    // Hazardous inputs while rst is held: outputs must still be zero.
    apply(br());
    exp_q.push_back(O_ZERO);
    #2;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_held got=%b want=%b", got, want); end
    @(posedge clk); #2;
    rst = 1'b0;
    apply(idle());
    next_cycle();
    apply(idle()); exp_q.push_back(O_NORMAL); #3;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_release got=%b want=%b", got, want); end
    // Start a flush, then abort it with a mid-cycle reset.
    next_cycle();
    apply(br()); exp_q.push_back(O_FLUSH); #3;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_pre_flush got=%b want=%b", got, want); end
    apply(idle());
    rst = 1'b1; exp_q.push_back(O_ZERO); #0.5;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_async_flush got=%b want=%b", got, want); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    apply(idle()); exp_q.push_back(O_NORMAL); #3;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_no_residual_flush got=%b want=%b", got, want); end
    // Same for a memory wait.
    next_cycle();
    apply(mwait()); exp_q.push_back(O_STALL); #3;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_pre_wait got=%b want=%b", got, want); end
    rst = 1'b1; exp_q.push_back(O_ZERO); #0.5;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_async_wait got=%b want=%b", got, want); end
    apply(idle());
    next_cycle();
    rst = 1'b0;
    next_cycle();
    apply(idle()); exp_q.push_back(O_NORMAL); #3;
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_no_residual_wait got=%b want=%b", got, want); end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [3:0] e[$]; logic [3:0] got, want;
    s.push_back(lu());                             e.push_back(O_STALL);
    s.push_back(mk(5, 0, 1, 0, 0, 1, 0, 0, 0));    e.push_back(O_NORMAL); // x0
    s.push_back(mk(5, 0, 0, 0, 5, 1, 0, 0, 0));    e.push_back(O_NORMAL); // rs1 unused
    s.push_back(mk(0, 9, 0, 1, 9, 1, 0, 0, 0));    e.push_back(O_STALL);  // via rs2
    s.push_back(mk(0, 9, 0, 1, 9, 0, 0, 0, 0));    e.push_back(O_NORMAL); // not a load
    s.push_back(mk(3, 4, 1, 1, 7, 1, 0, 0, 0));    e.push_back(O_NORMAL); // no match
    s.push_back(idle());                           e.push_back(O_NORMAL);
    for (int i = 0; i < s.size(); i++) begin
      next_cycle();
      apply(s[i]); exp_q.push_back(e[i]); #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [3:0] e[$]; logic [3:0] got, want;
    // Single pulse: exactly two flush cycles.
    s.push_back(br());   e.push_back(O_FLUSH);
    s.push_back(idle()); e.push_back(O_FLUSH);
    s.push_back(idle()); e.push_back(O_NORMAL);
    // Second pulse in cycle 2 extends to three; load_use suppressed in FLUSH.
    s.push_back(br());   e.push_back(O_FLUSH);
    s.push_back(br());   e.push_back(O_FLUSH);
    s.push_back(lu());   e.push_back(O_FLUSH);
    s.push_back(idle()); e.push_back(O_NORMAL);
    for (int i = 0; i < s.size(); i++) begin
      next_cycle();
      apply(s[i]); exp_q.push_back(e[i]); #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL branch[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_priority();
    stim_t s[$]; logic [3:0] e[$]; logic [3:0] got, want;
    s.push_back(mk(5, 0, 1, 0, 5, 1, 1, 0, 0)); e.push_back(O_FLUSH);  // branch beats load_use
    s.push_back(idle());                        e.push_back(O_FLUSH);
    s.push_back(idle());                        e.push_back(O_NORMAL);
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(O_STALL);  // wait beats branch
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(O_NORMAL); // ready, no branch
    s.push_back(idle());                        e.push_back(O_NORMAL);
    for (int i = 0; i < s.size(); i++) begin
      next_cycle();
      apply(s[i]); exp_q.push_back(e[i]); #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL priority[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[$]; logic [3:0] e[$]; logic [3:0] got, want;
    for (int k = 0; k < 4; k++) begin
      s.push_back(mwait()); e.push_back(O_STALL);
    end
    s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1)); e.push_back(O_FLUSH);  // ready + branch
    s.push_back(idle());                        e.push_back(O_FLUSH);
    s.push_back(idle());                        e.push_back(O_NORMAL);
    s.push_back(mwait());                       e.push_back(O_STALL);
    s.push_back(mk(5, 0, 1, 0, 5, 1, 0, 1, 1)); e.push_back(O_STALL);  // ready + load_use
    s.push_back(idle());                        e.push_back(O_NORMAL);
    for (int i = 0; i < s.size(); i++) begin
      next_cycle();
      apply(s[i]); exp_q.push_back(e[i]); #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mem_wait[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; logic [3:0] e[$]; logic [3:0] got, want;
    s.push_back(lu());   e.push_back(O_STALL);
    s.push_back(lu());   e.push_back(O_STALL);
    s.push_back(br());   e.push_back(O_FLUSH);
    s.push_back(idle()); e.push_back(O_FLUSH);
    s.push_back(lu());   e.push_back(O_STALL);
    s.push_back(br());   e.push_back(O_FLUSH);
    s.push_back(mwait()); e.push_back(O_STALL); // freeze in FLUSH drops the count
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); e.push_back(O_NORMAL);
    s.push_back(idle()); e.push_back(O_NORMAL);
    for (int i = 0; i < s.size(); i++) begin
      next_cycle();
      apply(s[i]); exp_q.push_back(e[i]); #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want); end
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    logic [3:0] got, want;
    next_cycle();
    apply(idle());
    rst = 1'b1; #1; rst = 1'b0;
    cnt_q.push_back({2'd0, 2'd0}); #1;
    got = {stall_cycles, flush_events}; want = cnt_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL stats_reset got=%b want=%b", got, want); end
    for (int k = 0; k < 5; k++) begin
      next_cycle(); apply(mwait());
    end
    next_cycle(); apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
    next_cycle(); apply(idle());
    cnt_q.push_back({2'd3, 2'd1}); #3;
    got = {stall_cycles, flush_events}; want = cnt_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL stats_saturate got=%b want=%b", got, want); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    apply(idle());
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_mem_wait();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
